// File: rtl/health_monitor_scheduler_if.sv
// Bundle between the health monitor scheduler (slave) and its host/sensor front-end (master).
interface health_monitor_scheduler_if;
    logic       start;
    logic       sampleValid;
    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic       fallDetected;
    logic [3:0] glycemicIndex;
    logic       temperatureAbnormality;
    logic       alarmAck;
    logic [4:0] sampleReq;
    logic       busy;
    logic [4:0] alarmVec;
    logic       alarmValid;
    logic [2:0] alarmCode;
    logic [4:0] sensorFault;

    modport master (
        output start, sampleValid, presureAbnormality, bloodAbnormality, fallDetected,
               glycemicIndex, temperatureAbnormality, alarmAck,
        input  sampleReq, busy, alarmVec, alarmValid, alarmCode, sensorFault
    );

    modport slave (
        input  start, sampleValid, presureAbnormality, bloodAbnormality, fallDetected,
               glycemicIndex, temperatureAbnormality, alarmAck,
        output sampleReq, busy, alarmVec, alarmValid, alarmCode, sensorFault
    );
endinterface

// File: rtl/health_monitor_scheduler.sv
// Round-robin sequencer for five health detectors with persistence-filtered sticky alarms.
// Define HMS_TIMEOUT_EN to abandon a channel after TIMEOUT_CYCLES without sampleValid.
module health_monitor_scheduler #(
    parameter int         PERSIST        = 3,
    parameter logic [3:0] GI_LIMIT       = 4'd10,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    health_monitor_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, EVAL, NEXT} state_t;
    localparam logic [2:0] PERSIST_C = 3'(PERSIST);

    state_t     state;
    logic [2:0] ch;
    logic [2:0] ch_inc;
    logic [2:0] cnt [5];
    logic [2:0] cnt_cur;
    logic [2:0] cnt_new;
    logic       abn_now;
    logic       abn_q;
    logic [4:0] ch_onehot;
    logic [4:0] inc_onehot;
    logic [2:0] code;

`ifdef HMS_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wait_cnt;
`else
    assign bus.sensorFault = 5'd0;
`endif

    always_comb begin
        abn_now = 1'b0;
        cnt_cur = 3'd0;
        case (ch)
            3'd0: begin abn_now = bus.presureAbnormality;         cnt_cur = cnt[0]; end
            3'd1: begin abn_now = bus.bloodAbnormality;           cnt_cur = cnt[1]; end
            3'd2: begin abn_now = bus.fallDetected;               cnt_cur = cnt[2]; end
            3'd3: begin abn_now = (bus.glycemicIndex >= GI_LIMIT); cnt_cur = cnt[3]; end
            3'd4: begin abn_now = bus.temperatureAbnormality;     cnt_cur = cnt[4]; end
            default: ;
        endcase
    end

    assign ch_inc     = (ch == 3'd4) ? 3'd0 : ch + 3'd1;
    assign ch_onehot  = 5'b00001 << ch;
    assign inc_onehot = 5'b00001 << ch_inc;
    assign cnt_new    = !abn_q ? 3'd0 : (cnt_cur >= PERSIST_C) ? PERSIST_C : cnt_cur + 3'd1;

    // Fixed clinical priority: fall, pressure, temperature, blood, glycemic.
    always_comb begin
        if      (bus.alarmVec[2]) code = 3'd2;
        else if (bus.alarmVec[0]) code = 3'd0;
        else if (bus.alarmVec[4]) code = 3'd4;
        else if (bus.alarmVec[1]) code = 3'd1;
        else if (bus.alarmVec[3]) code = 3'd3;
        else                      code = 3'd7;
    end

    assign bus.alarmCode  = code;
    assign bus.alarmValid = |bus.alarmVec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ch            <= 3'd0;
            abn_q         <= 1'b0;
            bus.sampleReq <= 5'd0;
            bus.busy      <= 1'b0;
            bus.alarmVec  <= 5'd0;
            for (int i = 0; i < 5; i++) cnt[i] <= 3'd0;
`ifdef HMS_TIMEOUT_EN
            wait_cnt        <= '0;
            bus.sensorFault <= 5'd0;
`endif
        end else begin
            // Ack clears first; the EVAL writes below override it for the active channel.
            if (bus.alarmAck) begin
                bus.alarmVec <= 5'd0;
                for (int i = 0; i < 5; i++) cnt[i] <= 3'd0;
`ifdef HMS_TIMEOUT_EN
                bus.sensorFault <= 5'd0;
`endif
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= REQ;
                        bus.sampleReq <= ch_onehot;
                        bus.busy      <= 1'b1;
`ifdef HMS_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.sampleValid) begin
                        abn_q         <= abn_now;
                        state         <= EVAL;
                        bus.sampleReq <= 5'd0;
                    end
`ifdef HMS_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        bus.sensorFault[ch] <= 1'b1;
                        state               <= NEXT;
                        bus.sampleReq       <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                EVAL: begin
                    cnt[ch] <= cnt_new;
                    if (cnt_new == PERSIST_C) bus.alarmVec[ch] <= 1'b1;
                    state <= NEXT;
                end
                NEXT: begin
                    ch <= ch_inc;
                    if (bus.start) begin
                        state         <= REQ;
                        bus.sampleReq <= inc_onehot;
`ifdef HMS_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_health_monitor_scheduler.sv
// Scoreboard bench: each serviced channel pushes a model prediction and the DUT's response two cycles later.
module tb_health_monitor_scheduler;
    localparam int PERSIST = 3;
    localparam int BUDGET  = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    health_monitor_scheduler_if bus ();
    health_monitor_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    int          m_ch;
    int          m_cnt [5];
    logic [4:0]  m_alarm;
    logic [13:0] exp_q [$];
    logic [13:0] obs_q [$];

    function automatic logic [2:0] prio(input logic [4:0] v);
        if (v[2]) return 3'd2;
        if (v[0]) return 3'd0;
        if (v[4]) return 3'd4;
        if (v[1]) return 3'd1;
        if (v[3]) return 3'd3;
        return 3'd7;
    endfunction

    task automatic model_reset();
        m_ch    = 0;
        m_alarm = 5'd0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endtask

    task automatic set_flags(input logic p, input logic b, input logic f, input logic [3:0] g, input logic t);
        bus.presureAbnormality     = p;
        bus.bloodAbnormality       = b;
        bus.fallDetected           = f;
        bus.glycemicIndex          = g;
        bus.temperatureAbnormality = t;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        exp_q.delete();
        obs_q.delete();
    endtask

    // Services one channel with sampleValid held high; records prediction and observation.
    task automatic step_channel();
        int         waited;
        logic       abn;
        logic [4:0] req;
        waited = 0;
        while (bus.sampleReq == 5'd0 && waited < BUDGET) begin
            @(posedge clk); #1;
            waited++;
        end
        req = bus.sampleReq;
        case (m_ch)
            0:       abn = bus.presureAbnormality;
            1:       abn = bus.bloodAbnormality;
            2:       abn = bus.fallDetected;
            3:       abn = (bus.glycemicIndex >= 4'd10);
            default: abn = bus.temperatureAbnormality;
        endcase
        if (abn) m_cnt[m_ch] = (m_cnt[m_ch] >= PERSIST) ? PERSIST : m_cnt[m_ch] + 1;
        else     m_cnt[m_ch] = 0;
        if (m_cnt[m_ch] == PERSIST) m_alarm[m_ch] = 1'b1;
        exp_q.push_back({5'(5'b00001 << m_ch), m_alarm, |m_alarm, prio(m_alarm)});
        m_ch = (m_ch == 4) ? 0 : m_ch + 1;
        if (waited >= BUDGET) begin
            obs_q.push_back('x);
        end else begin
            repeat (2) begin @(posedge clk); #1; end
            obs_q.push_back({req, bus.alarmVec, bus.alarmValid, bus.alarmCode});
        end
    endtask

    task automatic test_reset();
        logic [13:0] e, o;
        set_flags(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        bus.start = 1'b0; bus.sampleValid = 1'b0; bus.alarmAck = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.sampleReq, bus.busy, bus.alarmVec, bus.alarmValid, bus.alarmCode, bus.sensorFault}
            !== {5'd0, 1'b0, 5'd0, 1'b0, 3'd7, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_hold: got req=%b busy=%b vec=%b vld=%b code=%0d flt=%b, want 0/0/0/0/7/0",
                     bus.sampleReq, bus.busy, bus.alarmVec, bus.alarmValid, bus.alarmCode, bus.sensorFault);
        end
        rst = 1'b0;
        model_reset();
        bus.start = 1'b1; bus.sampleValid = 1'b1;
        step_channel();
        step_channel();
        bus.sampleValid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (bus.sampleReq !== 5'b00100) begin
            miscompares++;
            $display("FAIL mid_req: got sampleReq=%b want 00100", bus.sampleReq);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.sampleReq, bus.busy, bus.alarmVec, bus.alarmValid, bus.alarmCode, bus.sensorFault}
            !== {5'd0, 1'b0, 5'd0, 1'b0, 3'd7, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_async: got req=%b busy=%b vec=%b vld=%b code=%0d flt=%b, want 0/0/0/0/7/0",
                     bus.sampleReq, bus.busy, bus.alarmVec, bus.alarmValid, bus.alarmCode, bus.sensorFault);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        bus.sampleValid = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset_scan: got %h want %h", o, e); end
        end
        // First channel after reset must be ch0 again.
        step_channel();
        e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL reset_resume: got %h want %h", o, e); end
    endtask

    task automatic test_persistence();
        logic [13:0] e, o;
        reset_dut();
        set_flags(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        repeat (15) step_channel();
        vectors++;
        if (bus.alarmVec !== 5'b00100 || bus.alarmCode !== 3'd2) begin
            miscompares++;
            $display("FAIL persist_final: got vec=%b code=%0d want 00100/2", bus.alarmVec, bus.alarmCode);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL persist_step: got %h want %h", o, e); end
        end
    endtask

    task automatic test_interrupted();
        logic [13:0] e, o;
        reset_dut();
        set_flags(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (10) step_channel();
        bus.presureAbnormality = 1'b0;
        repeat (5) step_channel();
        bus.presureAbnormality = 1'b1;
        repeat (10) step_channel();
        vectors++;
        if (bus.alarmVec !== 5'b00000) begin
            miscompares++;
            $display("FAIL interrupted_final: got vec=%b want 00000", bus.alarmVec);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL interrupted_step: got %h want %h", o, e); end
        end
    endtask

    task automatic test_glycemic();
        logic [13:0] e, o;
        reset_dut();
        set_flags(1'b1, 1'b0, 1'b0, 4'd9, 1'b0);
        repeat (15) step_channel();
        vectors++;
        if (bus.alarmVec !== 5'b00001 || bus.alarmCode !== 3'd0) begin
            miscompares++;
            $display("FAIL gi9_final: got vec=%b code=%0d want 00001/0", bus.alarmVec, bus.alarmCode);
        end
        bus.glycemicIndex = 4'd10;
        repeat (15) step_channel();
        vectors++;
        if (bus.alarmVec !== 5'b01001 || bus.alarmCode !== 3'd0) begin
            miscompares++;
            $display("FAIL gi10_final: got vec=%b code=%0d want 01001/0", bus.alarmVec, bus.alarmCode);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL glycemic_step: got %h want %h", o, e); end
        end
    endtask

    task automatic test_ack_collision();
        logic [13:0] e, o;
        int          waited;
        reset_dut();
        set_flags(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        repeat (12) step_channel();
        vectors++;
        if (bus.alarmVec !== 5'b00001) begin
            miscompares++;
            $display("FAIL ack_pre: got vec=%b want 00001", bus.alarmVec);
        end
        waited = 0;
        while (bus.sampleReq == 5'd0 && waited < BUDGET) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (bus.sampleReq !== 5'b00100) begin
            miscompares++;
            $display("FAIL ack_req: got sampleReq=%b want 00100", bus.sampleReq);
        end
        @(posedge clk); #1 bus.alarmAck = 1'b1;
        @(posedge clk); #1 bus.alarmAck = 1'b0;
        vectors++;
        if (bus.alarmVec !== 5'b00100 || bus.alarmCode !== 3'd2) begin
            miscompares++;
            $display("FAIL ack_collision: got vec=%b code=%0d want 00100/2", bus.alarmVec, bus.alarmCode);
        end
        m_alarm = 5'b00100;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_cnt[2] = PERSIST;
        m_ch     = 3;
        // Pressure restarts from zero after the ack, so one more scan must not re-raise it.
        repeat (8) step_channel();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL ack_step: got %h want %h", o, e); end
        end
    endtask

    task automatic test_start_stop();
        logic [13:0] e, o;
        reset_dut();
        set_flags(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (2) step_channel();
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (bus.busy !== 1'b0 || bus.sampleReq !== 5'd0) begin
            miscompares++;
            $display("FAIL stop_idle: got busy=%b req=%b want 0/00000", bus.busy, bus.sampleReq);
        end
        bus.start = 1'b1;
        repeat (8) step_channel();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL resume_step: got %h want %h", o, e); end
        end
    endtask

`ifdef HMS_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        set_flags(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step_channel();
        bus.sampleValid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.sampleReq !== 5'b00010) begin
            miscompares++;
            $display("FAIL timeout_req: got req=%b want 00010", bus.sampleReq);
        end
        repeat (15) begin @(posedge clk); #1; end
        vectors++;
        if (bus.sensorFault !== 5'd0) begin
            miscompares++;
            $display("FAIL timeout_early: got fault=%b want 00000", bus.sensorFault);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.sensorFault !== 5'b00010) begin
            miscompares++;
            $display("FAIL timeout_fault: got fault=%b want 00010", bus.sensorFault);
        end
        bus.sampleValid = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_persistence();
        test_interrupted();
        test_glycemic();
        test_ack_collision();
        test_start_stop();
`ifdef HMS_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
